// File: rtl/lab4_display_scanner.sv
// lab4_display_scanner: 4-digit multiplexed 7-segment driver with frame-synchronous double-buffered value
module lab4_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        display_on,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  cathode,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [111:0] SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d, shadow_q, shadow_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          frame_done_q, frame_done_d;
  logic          tick, wrap, blank, lit;
  logic [3:0]    nib;
  always_comb begin
    tick         = cnt_q == CW'(REFRESH_DIV - 1);
    wrap         = tick && idx_q == 2'd3;
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    pending_d    = load ? value : pending_q;
    pend_valid_d = wrap ? 1'b0 : (load ? 1'b1 : pend_valid_q);
    shadow_d     = wrap ? (load ? value : (pend_valid_q ? pending_q : shadow_q)) : shadow_q;
    nib          = shadow_d[{idx_d, 2'b00} +: 4];
    blank        = BLANK_LZ != 0 && idx_d != 2'd0 && (shadow_d >> {idx_d, 2'b00}) == 16'h0;
    lit          = display_on && digit_en[idx_d] && !blank;
    an_d         = tick ? (lit ? ~(4'b0001 << idx_d) : 4'hF) : an_q;
    cathode_d    = tick ? (lit ? SEG[{nib, 3'b000} - {3'b000, nib} +: 7] : 7'h7F) : cathode_q;
    frame_done_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd3;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      an_q         <= 4'hF;
      cathode_q    <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign an         = an_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;
endmodule

// File: doc/lab4_display_scanner.md
Name: lab4_display_scanner

Overview:
- Time-multiplexed driver for the 4-digit common-anode 7-segment display; the sequential counterpart of the lab3 single-digit decoder.
- Takes a 16-bit hex value (4 nibbles) and cycles one active-low anode at a time at a fixed refresh rate.
- Drives the matching active-low cathode pattern for the selected digit.
- Value updates are double-buffered so they apply only at a frame boundary (no tearing).

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is held; legal range 2..2^20.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- display_on  input  1  1 = display enabled; 0 = all anodes off, scan keeps running.
- value  input  16  digit3=value[15:12] … digit0=value[3:0].
- load  input  1  one-cycle strobe; value sampled into pending register.
- digit_en  input  4  per-digit enable, bit i = digit i; sampled live, not buffered.
- an  output  4  anode select, active-low, registered.
- cathode  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- frame_done  output  1  one-cycle pulse on each digit 3→0 wrap.

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=3, pending=0, pend_valid=0, shadow=0, an=4'b1111, cathode=7'h7F, frame_done=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 in the cycle where the count is REFRESH_DIV-1.
- Digit index: on a tick edge, idx <= idx+1 mod 4.
  - Wrap 3→0 happens on the first tick after reset, so the first shown digit is 0, REFRESH_DIV cycles after reset release.
- Outputs:
  - an and cathode update only on tick edges, on the same edge idx advances, and reflect the new idx and current shadow.
  - Between ticks they hold, even if display_on or digit_en change.
- Digit lit when display_on=1, digit_en[new idx]=1, and it is not leading-zero blanked.
  - Lit: an = ~(4'b0001 << new idx), cathode = pattern(shadow nibble).
  - Otherwise: an=4'b1111, cathode=7'h7F.
- Leading-zero blanking (BLANK_LZ=1): digit k (k≥1) blanked if shadow nibbles k..3 are all 0.
- Cathode patterns, active-low:
  - 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001  5:0010010  6:0000010  7:1111000
  - 8:0000000  9:0010000  A:0001000  b:0000011  C:1000110  d:0100001  E:0000110  F:0001110
- Load handshake:
  - load=1: pending <= value, pend_valid <= 1.
  - Multiple loads before a wrap: last wins.
- Wrap edge (tick with idx=3):
  - If pend_valid: shadow <= pending, pend_valid <= 0.
  - The new shadow drives digit 0's cathode on that same edge.
  - frame_done=1 for exactly that cycle.
- load in the same cycle as a wrap tick: value goes straight to shadow, used for digit 0 on that edge; pend_valid ends 0.
- Load latency: displayed at the next wrap; worst case 4*REFRESH_DIV cycles.
- Reset mid-frame: immediate return to reset values. Any pending value is discarded.

Test Plan:
- REFRESH_DIV=4, BLANK_LZ=0, release reset, display_on=1, digit_en=4'hF, load value 16'h12AF
  - → an=1111/cathode=7F for the first 3 cycles after release.
  - → at cycle 4 (first tick, wrap), an=1110, cathode=0001110 (F), frame_done=1 for one cycle.
  - → then every 4 cycles: an=1101/0001000 (A), an=1011/0100100 (2), an=0111/1111001 (1).
  - → frame_done pulses every 16 cycles.
- Mid-frame, loads of 16'h0000 then 16'h8888 while idx=1
  - → digits 2,3 still show old value.
  - → at the next wrap, all digits show 0000000.
- load of 16'h5555 asserted exactly in the wrap tick cycle
  - → digit 0 shows 0010010 on that same edge.
  - → pend_valid=0 afterwards.
- display_on=0 for one full frame, then 1
  - → an=1111, cathode=7F at every tick while off; frame_done still pulses.
  - → normal patterns resume at the first tick after display_on=1.
- digit_en=4'b0101
  - → an=1110 and an=1011 in their slots; slots for digits 1 and 3 show 1111/7F.
- BLANK_LZ=1, value 16'h0030
  - → digits 3,2 blank, digit 1 shows 0110000, digit 0 shows 1000000.
- Assert rst_n=0 mid-frame
  - → an=1111, cathode=7F immediately, without a clock edge.
  - → after release, a previously pending value is not shown; digits display 0.
